// File: rtl/data_mem_ctrl_if.sv
// Processor-side data request/response bundle for data_mem_ctrl.
interface data_mem_ctrl_if #(
  parameter int unsigned WORD_SIZE = 16
);
  logic [WORD_SIZE-1:0] DataAddr;
  logic [WORD_SIZE-1:0] DataOut;
  logic                 ReadData;
  logic                 WriteData;
  logic [WORD_SIZE-1:0] DataIn;
  logic                 DataDone;
  logic                 Busy;
  logic                 ProtoErr;

  modport master (
    output DataAddr, DataOut, ReadData, WriteData,
    input  DataIn, DataDone, Busy, ProtoErr
  );

  modport slave (
    input  DataAddr, DataOut, ReadData, WriteData,
    output DataIn, DataDone, Busy, ProtoErr
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: services single-cycle load/store requests against an internal RAM
// with programmable latency. Optional one-entry last-read hit path under DMEM_LAST_HIT_EN.
module data_mem_ctrl #(
  parameter int unsigned WORD_SIZE     = 16,
  parameter int unsigned ADDR_BITS     = 8,
  parameter int unsigned READ_LATENCY  = 2,
  parameter int unsigned WRITE_LATENCY = 1
) (
  input  logic            Clock,
  input  logic            Reset,
  data_mem_ctrl_if.slave  bus
);
  localparam int unsigned DEPTH   = 2 ** ADDR_BITS;
  localparam int unsigned MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int unsigned CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d, req_addr;
  logic [WORD_SIZE-1:0] data_q, data_d, din_q, din_d, hit_rdata;
  logic                 wr_q, wr_d, err_q, err_d, done_q, busy_q;
  logic                 req, hit, mem_we, rd_done;
  logic                 unused_addr;
  logic [WORD_SIZE-1:0] mem [DEPTH];

  assign req_addr    = bus.DataAddr[ADDR_BITS-1:0];
  assign req         = bus.ReadData | bus.WriteData;
  assign unused_addr = ^bus.DataAddr;

`ifdef DMEM_LAST_HIT_EN
  logic                 hit_valid_q, hit_valid_d;
  logic [ADDR_BITS-1:0] hit_tag_q, hit_tag_d;
  logic [WORD_SIZE-1:0] hit_data_q, hit_data_d;

  assign hit       = bus.ReadData & ~bus.WriteData & hit_valid_q & (hit_tag_q == req_addr);
  assign hit_rdata = hit_data_q;

  // Entry follows completed reads; writes to the cached word keep it coherent.
  always_comb begin
    hit_valid_d = hit_valid_q;
    hit_tag_d   = hit_tag_q;
    hit_data_d  = hit_data_q;
    if (rd_done) begin
      hit_valid_d = 1'b1;
      hit_tag_d   = addr_q;
      hit_data_d  = mem[addr_q];
    end
    if (mem_we && (hit_tag_q == addr_q)) hit_data_d = data_q;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      hit_valid_q <= 1'b0;
      hit_tag_q   <= '0;
      hit_data_q  <= '0;
    end else begin
      hit_valid_q <= hit_valid_d;
      hit_tag_q   <= hit_tag_d;
      hit_data_q  <= hit_data_d;
    end
  end
`else
  assign hit       = 1'b0;
  assign hit_rdata = '0;
`endif

  // Next-state and datapath decisions.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wr_d    = wr_q;
    err_d   = err_q;
    din_d   = '0;
    mem_we  = 1'b0;
    rd_done = 1'b0;
    unique case (state_q)
      IDLE, RESP: begin
        if (req) begin
          addr_d = req_addr;
          data_d = bus.DataOut;
          wr_d   = bus.WriteData;
          if (bus.ReadData && bus.WriteData) err_d = 1'b1;
          if (hit) begin
            state_d = RESP;
            din_d   = hit_rdata;
          end else begin
            state_d = BUSY;
            cnt_d   = bus.WriteData ? CNT_W'(WRITE_LATENCY - 1) : CNT_W'(READ_LATENCY - 1);
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        // A stalled processor re-presents its request; only a changed address is an error.
        if (req && (req_addr != addr_q)) err_d = 1'b1;
        if (cnt_q == '0) begin
          state_d = RESP;
          if (wr_q) begin
            mem_we = 1'b1;
          end else begin
            rd_done = 1'b1;
            din_d   = mem[addr_q];
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      din_q   <= '0;
      done_q  <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      din_q   <= din_d;
      done_q  <= (state_d != BUSY);
      busy_q  <= (state_d == BUSY);
    end
  end

  // RAM has no reset; a write completing under reset is dropped.
  always_ff @(posedge Clock) begin
    if (mem_we && !Reset) mem[addr_q] <= data_q;
  end

  assign bus.DataIn   = din_q;
  assign bus.DataDone = done_q;
  assign bus.Busy     = busy_q;
  assign bus.ProtoErr = err_q;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Randomized self-checking bench for data_mem_ctrl against a transaction-level memory model.
module tb_data_mem_ctrl;
  localparam int unsigned WORD_SIZE     = 16;
  localparam int unsigned ADDR_BITS     = 8;
  localparam int unsigned READ_LATENCY  = 2;
  localparam int unsigned WRITE_LATENCY = 1;

  logic Clock = 1'b0;
  logic Reset = 1'b1;

  data_mem_ctrl_if #(.WORD_SIZE(WORD_SIZE)) bus ();

  data_mem_ctrl #(
    .WORD_SIZE    (WORD_SIZE),
    .ADDR_BITS    (ADDR_BITS),
    .READ_LATENCY (READ_LATENCY),
    .WRITE_LATENCY(WRITE_LATENCY)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (bus)
  );

  always #5 Clock = ~Clock;

  logic [15:0] ref_mem [256];
  bit          hvalid;
  logic [7:0]  htag;
  bit          err_exp;
  int          checks;
  int          failures;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle_cycle();
    bus.ReadData  = 1'b0;
    bus.WriteData = 1'b0;
    tick();
    check_val("idle_done", 32'(bus.DataDone), 32'd1);
    check_val("idle_busy", 32'(bus.Busy), 32'd0);
    check_val("idle_din",  32'(bus.DataIn), 32'd0);
    check_val("idle_err",  32'(bus.ProtoErr), 32'(err_exp));
  endtask

  // Present one request from IDLE/RESP; returns with the DUT in its RESP cycle.
  // redrive: 0 drop strobe, 1 re-present same word (random upper bits), 2 re-present another word.
  task automatic issue(input bit rd, input bit wr, input logic [15:0] addr,
                       input logic [15:0] data, input int redrive);
    int          exp_lat;
    int          n;
    logic [7:0]  a;
    logic [15:0] exp_din;
    a = addr[7:0];
    if (rd && wr) err_exp = 1'b1;
    exp_lat = wr ? int'(WRITE_LATENCY) : int'(READ_LATENCY);
`ifdef DMEM_LAST_HIT_EN
    if (!wr && hvalid && htag == a) exp_lat = 0;
`endif
    exp_din = wr ? 16'h0000 : ref_mem[a];
    bus.ReadData  = rd;
    bus.WriteData = wr;
    bus.DataAddr  = addr;
    bus.DataOut   = data;
    tick();
    if (redrive == 0) begin
      bus.ReadData  = 1'b0;
      bus.WriteData = 1'b0;
      bus.DataAddr  = 16'($urandom);
    end else if (redrive == 1) begin
      bus.DataAddr = {8'($urandom), a};
    end else begin
      bus.DataAddr = {8'($urandom), a ^ 8'h5A};
    end
    n = 0;
    while (bus.DataDone !== 1'b1 && n < 20) begin
      check_val("busy_flag", 32'(bus.Busy), 32'd1);
      check_val("busy_din",  32'(bus.DataIn), 32'd0);
      check_val("busy_err",  32'(bus.ProtoErr), 32'(err_exp));
      if (redrive == 2 && (bus.ReadData || bus.WriteData)) err_exp = 1'b1;
      n++;
      tick();
    end
    bus.ReadData  = 1'b0;
    bus.WriteData = 1'b0;
    check_val("latency",   32'(n), 32'(exp_lat));
    check_val("resp_done", 32'(bus.DataDone), 32'd1);
    check_val("resp_busy", 32'(bus.Busy), 32'd0);
    check_val("resp_din",  32'(bus.DataIn), 32'(exp_din));
    check_val("resp_err",  32'(bus.ProtoErr), 32'(err_exp));
    if (wr) begin
      ref_mem[a] = data;
    end else begin
      hvalid = 1'b1;
      htag   = a;
    end
  endtask

  initial begin
    int r;
    checks = 0;
    failures = 0;
    hvalid = 1'b0;
    htag = '0;
    err_exp = 1'b0;
    bus.ReadData  = 1'b0;
    bus.WriteData = 1'b0;
    bus.DataAddr  = '0;
    bus.DataOut   = '0;

    // Reset, then quiet cycles.
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) idle_cycle();

    // Give every RAM word a known value.
    for (int i = 0; i < 256; i++) issue(1'b0, 1'b1, 16'(i), 16'($urandom), 0);
    idle_cycle();

    // Write then read back.
    issue(1'b0, 1'b1, 16'h0005, 16'h1234, 0);
    idle_cycle();
    issue(1'b1, 1'b0, 16'h0005, 16'h0000, 0);
    idle_cycle();

    // Back-to-back reads with no IDLE bubble.
    issue(1'b1, 1'b0, 16'h0010, 16'h0000, 0);
    issue(1'b1, 1'b0, 16'h0007, 16'h0000, 0);
    idle_cycle();

    // Address aliasing.
    issue(1'b0, 1'b1, 16'h0105, 16'hBEEF, 0);
    idle_cycle();
    issue(1'b1, 1'b0, 16'h0005, 16'h0000, 0);
    check_val("alias_data", 32'(bus.DataIn), 32'h0000BEEF);
    idle_cycle();

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 15));
      if (r == 0)     issue(1'b1, 1'b1, 16'($urandom), 16'($urandom), int'($urandom_range(0, 1)));
      else if (r < 9) issue(1'b1, 1'b0, 16'($urandom_range(0, 1023)), 16'($urandom), int'($urandom_range(0, 1)));
      else            issue(1'b0, 1'b1, 16'($urandom_range(0, 1023)), 16'($urandom), int'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end
    idle_cycle();

    // Reset while a write is in flight drops the write.
    bus.WriteData = 1'b1;
    bus.DataAddr  = 16'h0009;
    bus.DataOut   = 16'hAAAA;
    tick();
    bus.WriteData = 1'b0;
    check_val("rst_busy_before", 32'(bus.Busy), 32'd1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    err_exp = 1'b0;
    hvalid  = 1'b0;
    check_val("rst_done", 32'(bus.DataDone), 32'd1);
    check_val("rst_busy", 32'(bus.Busy), 32'd0);
    check_val("rst_din",  32'(bus.DataIn), 32'd0);
    check_val("rst_err",  32'(bus.ProtoErr), 32'd0);
    idle_cycle();
    issue(1'b1, 1'b0, 16'h0009, 16'h0000, 0);
    idle_cycle();

    // Changed address while stalled raises the sticky error.
    issue(1'b1, 1'b0, 16'h0020, 16'h0000, 2);
    check_val("redrive_err", 32'(bus.ProtoErr), 32'd1);
    idle_cycle();

    // Both strobes: treated as a write, flags an error, then repeated reads.
    issue(1'b1, 1'b1, 16'h0003, 16'h5555, 0);
    idle_cycle();
    issue(1'b1, 1'b0, 16'h0003, 16'h0000, 0);
    check_val("both_rd1", 32'(bus.DataIn), 32'h00005555);
    issue(1'b1, 1'b0, 16'h0003, 16'h0000, 0);
    check_val("both_rd2", 32'(bus.DataIn), 32'h00005555);
    idle_cycle();
    idle_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
Data-memory controller sitting directly downstream of the processor's Execute/Memory1/Memory2 stages. It accepts the processor's single-cycle data request (ReadData/WriteData, DataAddr, DataOut) and services it against an internal word-addressed RAM with programmable latency. It answers on DataIn/DataDone, the handshake the Memory1 stage uses to decide whether to stall. While busy, DataDone is low. DataDone returns high for exactly one response cycle carrying read data.

Parameters:
WORD_SIZE, 16, data and address port width
ADDR_BITS, 8, RAM depth is 2**ADDR_BITS words; upper address bits are ignored
READ_LATENCY, 2, BUSY cycles for a read (>=1)
WRITE_LATENCY, 1, BUSY cycles for a write (>=1)

Ports:
Clock  input  1  single clock, all state on rising edge
Reset  input  1  synchronous, active-high reset
DataAddr  input  WORD_SIZE  request word address
DataOut  input  WORD_SIZE  store data from processor
ReadData  input  1  load request strobe
WriteData  input  1  store request strobe
DataIn  output  WORD_SIZE  load data to processor; valid only in RESP
DataDone  output  1  high = no outstanding access (IDLE) or response cycle (RESP)
Busy  output  1  high in BUSY state
ProtoErr  output  1  sticky protocol-violation flag

Behaviour:
- Interface: one clock domain. Reset is synchronous and active-high; Reset is sampled only on the rising edge of Clock.
- Reset values: state=IDLE, counter=0, DataDone=1, DataIn=0, Busy=0, ProtoErr=0. Reset does not clear RAM contents.
- States: IDLE, BUSY, RESP. DataDone=1 in IDLE and RESP; DataDone=0 in BUSY. All outputs are driven from registers.
- Accepting a request (in IDLE or RESP):
  - If ReadData or WriteData is high at the edge, capture addr=DataAddr[ADDR_BITS-1:0], data=DataOut and the rw kind.
  - Load the counter with READ_LATENCY-1 or WRITE_LATENCY-1, then go to BUSY.
- RESP with no new request: go to IDLE.
- Back-to-back: a request presented during RESP is accepted with no IDLE bubble.
- Timing for a request presented in cycle c with latency N:
  - DataDone=0 and Busy=1 in cycles c+1..c+N.
  - Cycle c+N+1 is RESP with DataDone=1.
- BUSY: the counter decrements each cycle. At counter==0 the next state is RESP.
  - Write: RAM[addr] is written at the BUSY->RESP edge.
  - Read: RAM[addr] is registered into DataIn at the BUSY->RESP edge.
- DataIn is held at 0 in every state except RESP. For a write, DataIn is 0 in RESP.
- Re-driven request in BUSY: the processor re-presents its request while stalled; this is ignored.
  - If the strobe is high and DataAddr[ADDR_BITS-1:0] differs from the captured addr, set ProtoErr.
- ReadData and WriteData both high when accepted: treat the access as a write and set ProtoErr.
- ProtoErr is sticky until Reset.
- Address wrap: only DataAddr[ADDR_BITS-1:0] is used, so addresses alias modulo 2**ADDR_BITS.
- Read-after-write ordering: a read accepted after a write's RESP cycle returns the written value.
- Reset mid-operation (BUSY or RESP): the next cycle is IDLE with DataDone=1; a pending write is dropped and RAM is unchanged.

Optional Feature:
Macro DMEM_LAST_HIT_EN.
- Defined:
  - Adds a one-entry last-read register (valid, tag, data).
  - A read whose addr matches a valid tag skips BUSY and goes straight to RESP the next cycle with the cached data. DataDone stays 1 throughout.
  - A completing read loads the entry.
  - A write whose addr matches the tag updates the entry's data at the write edge.
  - Reset clears valid.
- Undefined: no entry exists; every read takes READ_LATENCY BUSY cycles.

Test Plan:
1. Reset for 2 cycles, then release with no requests -> DataDone=1, DataIn=0x0000, Busy=0, ProtoErr=0 on every cycle.
2. Write 0x1234 to addr 0x0005 in cycle 10 -> DataDone=0 in cycle 11 only, RESP in cycle 12. Then read 0x0005 in cycle 13 -> DataDone=0 in cycles 14-15, cycle 16 DataDone=1 with DataIn=0x1234.
3. Read addr 0x0007 presented in the RESP cycle of a prior read -> accepted immediately, no IDLE cycle, second RESP exactly 3 cycles later.
4. Write 0xBEEF to 0x0105, then read 0x0005 -> DataIn=0xBEEF (alias), ProtoErr=0.
5. Write 0xAAAA to 0x0009 in cycle c, assert Reset in cycle c+1 (BUSY) -> cycle c+2 IDLE, DataDone=1; subsequent read of 0x0009 returns the prior contents, not 0xAAAA.
6. ReadData=WriteData=1 with DataOut=0x5555 at 0x0003 -> ProtoErr=1 and stays 1; read 0x0003 returns 0x5555. With DMEM_LAST_HIT_EN, a repeated read of 0x0003 gives DataDone=1 continuously and DataIn=0x5555 one cycle after the request.
